ram_port_arbiter: RTL and testbench

- Shares the single-port data/instruction RAM between two requesters:
  - the CPU controller's memory sequencing (fetch and MDR loads/stores);
  - a debug/loader port used to preload programs and inspect memory.
- Sits between controller_verilog's RAM_RD/RAM_WR/RAM_MUX path and the RAM.
- Serialises accesses, holds the CPU off with a stall while debug owns the RAM, and prevents debug starvation.

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/ram_arb_starve_ctr.sv | 27 ++
 rtl/ram_port_arbiter.sv | 111 +++++++++++
 tb/tb_ram_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding and owner identifiers.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating count of CPU grants made while debug waits; sat flags that debug must win next.
// Registered count, sat is combinational from it; clr has priority over inc.
module ram_arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != 4'(MAX))) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == 4'(MAX));

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port RAM between CPU and debug; write done 2 cycles after grant, read RAM_LAT+1.
// The losing/waiting CPU is held by cpu_stall; debug is forced through after STARVE_MAX CPU wins.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RAM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              Reset_in,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [2:0]        Stat_tst_out
);

  state_t            state, state_nxt;
  logic              owner;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [1:0]        lat_cnt;
  logic              grant, grant_dbg, lat_last, starve_sat;

  assign grant     = (state == IDLE) && (cpu_req || dbg_req);
  assign grant_dbg = dbg_req && (!cpu_req || starve_sat);
  assign lat_last  = (lat_cnt == 2'(RAM_LAT - 1));

  always_ff @(posedge clk or negedge Reset_in) begin
    if (!Reset_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req || dbg_req) state_nxt = ACCESS;
      ACCESS:  if (we_q || lat_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request inputs are only sampled on the grant edge; later changes cannot disturb the access.
  always_ff @(posedge clk or negedge Reset_in) begin
    if (!Reset_in) begin
      owner       <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else if (grant) begin
      owner   <= grant_dbg ? OWN_DBG : OWN_CPU;
      we_q    <= grant_dbg ? dbg_we : cpu_we;
      addr_q  <= grant_dbg ? dbg_addr : cpu_addr;
      wdata_q <= grant_dbg ? dbg_wdata : cpu_wdata;
      lat_cnt <= '0;
    end else if ((state == ACCESS) && !we_q) begin
      lat_cnt <= lat_cnt + 2'd1;
      if (lat_last) begin
        if (owner == OWN_DBG) dbg_rdata_q <= ram_rdata;
        else                  cpu_rdata_q <= ram_rdata;
      end
    end
  end

  ram_arb_starve_ctr #(
    .MAX(STARVE_MAX)
  ) u_starve (
    .clk  (clk),
    .rst_n(Reset_in),
    .inc  (grant && !grant_dbg && dbg_req),
    .clr  ((grant && grant_dbg) || ((state == IDLE) && !dbg_req)),
    .sat  (starve_sat)
  );

  assign ram_addr     = addr_q;
  assign ram_wdata    = wdata_q;
  assign ram_rd       = (state == ACCESS) && !we_q;
  assign ram_wr       = (state == ACCESS) && we_q;
  assign cpu_done     = (state == DONE) && (owner == OWN_CPU);
  assign dbg_done     = (state == DONE) && (owner == OWN_DBG);
  assign cpu_stall    = cpu_req && !cpu_done;
  assign cpu_rdata    = cpu_rdata_q;
  assign dbg_rdata    = dbg_rdata_q;
  assign Stat_tst_out = {owner, state};

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: instance A (RAM_LAT=2) for arbitration/latency, instance B (RAM_LAT=3) for reset abort.
module tb_ram_port_arbiter;

  typedef struct packed {
    logic        who;      // 0 = cpu_done expected, 1 = dbg_done expected
    logic [15:0] cpu_exp;
    logic [15:0] dbg_exp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, cpu_req, cpu_we, dbg_req, dbg_we;
  logic [7:0]  cpu_addr, dbg_addr, ram_addr;
  logic [15:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, ram_wdata, ram_rdata;
  logic        cpu_done, cpu_stall, dbg_done, ram_rd, ram_wr;
  logic [2:0]  stat;

  logic        rst_b, b_cpu_req, b_cpu_we, b_dbg_req, b_dbg_we;
  logic [7:0]  b_cpu_addr, b_dbg_addr, b_ram_addr;
  logic [15:0] b_cpu_wdata, b_dbg_wdata, b_cpu_rdata, b_dbg_rdata, b_ram_wdata, b_ram_rdata;
  logic        b_cpu_done, b_cpu_stall, b_dbg_done, b_ram_rd, b_ram_wr;
  logic [2:0]  b_stat;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .Reset_in(rst_a),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rdata(ram_rdata), .Stat_tst_out(stat)
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(16), .RAM_LAT(3), .STARVE_MAX(4)) dut_b (
    .clk(clk), .Reset_in(rst_b),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_done(b_cpu_done), .cpu_stall(b_cpu_stall),
    .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
    .dbg_rdata(b_dbg_rdata), .dbg_done(b_dbg_done),
    .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rd(b_ram_rd), .ram_wr(b_ram_wr),
    .ram_rdata(b_ram_rdata), .Stat_tst_out(b_stat)
  );

  // RAM models: data is only presented on the final read cycle, garbage otherwise.
  logic [15:0] mem_a [256];
  int rdc_a = 0, rdc_b = 0;
  always @(posedge clk) begin
    if (!rst_a) mem_a[8'h20] <= 16'hBEEF;
    else if (ram_wr) mem_a[ram_addr] <= ram_wdata;
    rdc_a <= ram_rd ? rdc_a + 1 : 0;
    rdc_b <= b_ram_rd ? rdc_b + 1 : 0;
  end
  assign ram_rdata   = (ram_rd && rdc_a == 1) ? mem_a[ram_addr] : 16'h0BAD;
  assign b_ram_rdata = (b_ram_rd && rdc_b == 2 && b_ram_addr == 8'h20) ? 16'hC0DE : 16'h0BAD;

  int checks = 0, errors = 0;
  exp_t qa[$], qb[$];
  exp_t ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic w, input logic [15:0] c, input logic [15:0] d);
    mk = {w, c, d};
  endfunction

  task automatic nc();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cpu_done || dbg_done) begin
      if (qa.size() == 0) begin
        chk("a_unexpected_done", {30'd0, cpu_done, dbg_done}, 32'd0);
      end else begin
        ea = qa.pop_front();
        chk("a_done_owner", {30'd0, cpu_done, dbg_done}, ea.who ? 32'd1 : 32'd2);
        chk("a_cpu_rdata", cpu_rdata, ea.cpu_exp);
        chk("a_dbg_rdata", dbg_rdata, ea.dbg_exp);
      end
    end
  end

  always @(negedge clk) begin
    if (b_cpu_done || b_dbg_done) begin
      if (qb.size() == 0) begin
        chk("b_unexpected_done", {30'd0, b_cpu_done, b_dbg_done}, 32'd0);
      end else begin
        eb = qb.pop_front();
        chk("b_done_owner", {30'd0, b_cpu_done, b_dbg_done}, eb.who ? 32'd1 : 32'd2);
        chk("b_cpu_rdata", b_cpu_rdata, eb.cpu_exp);
        chk("b_dbg_rdata", b_dbg_rdata, eb.dbg_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndbg, n;
    bit fin, got;
    rst_a = 0; rst_b = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = 0; b_cpu_wdata = 0;
    b_dbg_req = 0; b_dbg_we = 0; b_dbg_addr = 0; b_dbg_wdata = 0;
    nc(); nc();
    chk("reset_ctrl", {24'd0, ram_rd, ram_wr, cpu_done, dbg_done, cpu_stall, stat}, 32'd0);
    chk("reset_rdata", {cpu_rdata, dbg_rdata}, 32'd0);
    chk("reset_ram_bus", {8'd0, ram_addr, ram_wdata}, 32'd0);
    chk("reset_b", {b_ram_wr, b_ram_wdata, b_dbg_rdata}, 32'd0);
    rst_a = 1; rst_b = 1;
    nc();

    // CPU write 0x10 <= 0x1234
    chk("t1_stat_c0", stat, 3'b000);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 16'h1234;
    qa.push_back(mk(1'b0, 16'h0000, 16'h0000));
    #1 chk("t1_stall_c0", cpu_stall, 1);
    nc();
    chk("t1_stat_c1", stat, 3'b001);
    chk("t1_strobes_c1", {ram_rd, ram_wr}, 2'b01);
    chk("t1_addr_c1", ram_addr, 8'h10);
    chk("t1_wdata_c1", ram_wdata, 16'h1234);
    chk("t1_stall_c1", cpu_stall, 1);
    nc();
    chk("t1_stat_c2", stat, 3'b010);
    chk("t1_done_c2", cpu_done, 1);
    chk("t1_strobes_c2", {ram_rd, ram_wr}, 2'b00);
    chk("t1_stall_c2", cpu_stall, 0);
    cpu_req = 0;
    nc();
    chk("t1_stat_c3", stat, 3'b000);

    // Debug read 0x20 returns 0xBEEF after two read cycles
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h20;
    qa.push_back(mk(1'b1, 16'h0000, 16'hBEEF));
    nc();
    chk("t2_stat_c1", stat, 3'b101);
    chk("t2_strobes_c1", {ram_rd, ram_wr}, 2'b10);
    chk("t2_addr_c1", ram_addr, 8'h20);
    nc();
    chk("t2_strobes_c2", {ram_rd, ram_wr}, 2'b10);
    nc();
    chk("t2_stat_c3", stat, 3'b110);
    chk("t2_done_c3", dbg_done, 1);
    chk("t2_strobes_c3", {ram_rd, ram_wr}, 2'b00);
    dbg_req = 0;
    nc();
    chk("t2_stat_c4", stat, 3'b100);

    // Simultaneous requests: CPU first, debug on the following IDLE edge
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 16'h0055;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h10;
    qa.push_back(mk(1'b0, 16'h0000, 16'hBEEF));
    qa.push_back(mk(1'b1, 16'h0000, 16'h1234));
    nc();
    chk("t3_stat_c1", stat, 3'b001);
    nc();
    chk("t3_cpu_done_c2", cpu_done, 1);
    cpu_req = 0;
    #1 chk("t3_stall_c2", cpu_stall, 0);
    nc();
    chk("t3_stat_c3", stat, 3'b000);
    chk("t3_stall_c3", cpu_stall, 0);
    nc();
    chk("t3_stat_c4", stat, 3'b101);
    nc(); nc();
    chk("t3_dbg_done_c6", dbg_done, 1);
    dbg_req = 0;
    nc();

    // Starvation: 4 CPU grants then debug, twice; cleared counter gives CPU 4 more
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h40; cpu_wdata = 16'h0A0A;
    dbg_req = 1; dbg_we = 0; dbg_addr = 8'h30;
    for (int i = 0; i < 4; i++) qa.push_back(mk(1'b0, 16'h0000, 16'h1234));
    qa.push_back(mk(1'b1, 16'h0000, 16'h0055));
    for (int i = 0; i < 4; i++) qa.push_back(mk(1'b0, 16'h0000, 16'h0055));
    qa.push_back(mk(1'b1, 16'h0000, 16'h0055));
    qa.push_back(mk(1'b0, 16'h0000, 16'h0055));
    ndbg = 0; fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      nc();
      if (stat[2] && stat[1:0] != 2'b00) chk("t4_stall_during_dbg", cpu_stall, 1);
      if (dbg_done) begin
        ndbg++;
        if (ndbg == 2) dbg_req = 0;
      end else if (cpu_done && ndbg == 2) begin
        cpu_req = 0;
        fin = 1;
      end
    end
    if (!fin) chk("t4_timeout", 0, 1);
    nc();
    chk("t4_stat_end", stat, 3'b000);

    // Address latched at grant: later cpu_addr/we changes are ignored
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    qa.push_back(mk(1'b0, 16'h1234, 16'h0055));
    nc();
    chk("t6_addr_c1", ram_addr, 8'h10);
    cpu_addr = 8'h55; cpu_we = 1; cpu_wdata = 16'hFFFF;
    nc();
    chk("t6_addr_c2", ram_addr, 8'h10);
    chk("t6_strobes_c2", {ram_rd, ram_wr}, 2'b10);
    nc();
    chk("t6_done_c3", cpu_done, 1);
    chk("t6_addr_c3", ram_addr, 8'h10);
    cpu_req = 0;
    nc();
    chk("t6_stat_c4", stat, 3'b000);

    // Instance B: reset in mid-read abandons the access
    b_cpu_req = 1; b_cpu_we = 0; b_cpu_addr = 8'h20;
    nc();
    chk("t5_stat_c1", b_stat, 3'b001);
    chk("t5_rd_c1", b_ram_rd, 1);
    nc();
    chk("t5_rd_c2", b_ram_rd, 1);
    rst_b = 0; b_cpu_req = 0;
    #1;
    chk("t5_rd_in_reset", b_ram_rd, 0);
    chk("t5_stat_in_reset", b_stat, 3'b000);
    nc();
    chk("t5_no_done_1", b_cpu_done, 0);
    nc();
    chk("t5_no_done_2", b_cpu_done, 0);
    rst_b = 1;
    nc();
    chk("t5_stat_after", b_stat, 3'b000);
    chk("t5_rdata_after", b_cpu_rdata, 16'h0000);
    b_cpu_req = 1;
    qb.push_back(mk(1'b0, 16'hC0DE, 16'h0000));
    #1 chk("t5_stall_new", b_cpu_stall, 1);
    n = 0; got = 0;
    for (int i = 1; i <= 10 && !got; i++) begin
      nc();
      if (b_cpu_done) begin
        got = 1; n = i; b_cpu_req = 0;
      end
    end
    chk("t5_done_cycle", n, 4);
    nc(); nc();

    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
